// File: rtl/imem_pkg.sv
// Shared types and address decode for the instruction-memory responder.
package imem_pkg;

   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   // Widest word index the decode produces; the responder keeps the low $clog2(DEPTH) bits.
   localparam int unsigned IMEM_IDX_W = 32;

   typedef struct packed {
      logic                  err;
      logic [IMEM_IDX_W-1:0] idx;
   } imem_req_t;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] inst;
   } imem_rsp_t;

   typedef struct packed {
      logic                  misaligned;
      logic                  out_of_range;
      logic [IMEM_IDX_W-1:0] idx;
   } imem_dec_t;

   // Addresses below base wrap to huge offsets and so land in out_of_range.
   function automatic imem_dec_t imem_decode(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input logic [63:0] depth);
      imem_dec_t   dec;
      logic [63:0] off;
      off              = addr - base;
      dec.misaligned   = (off[1:0] != 2'b00);
      dec.out_of_range = ({2'b00, off[63:2]} >= depth);
      dec.idx          = off[IMEM_IDX_W+1:2];
      return dec;
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch and preload bus between the core/bench (master) and the instruction memory (slave).
interface imem_responder_if;

   logic        inst_ena;
   logic [63:0] inst_addr;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_err;
   logic        ld_ena;
   logic [63:0] ld_addr;
   logic [31:0] ld_data;
   logic [31:0] fetch_cnt;

   modport master (
      output inst_ena, inst_addr, ld_ena, ld_addr, ld_data,
      input  inst, inst_valid, inst_err, fetch_cnt
   );

   modport slave (
      input  inst_ena, inst_addr, ld_ena, ld_addr, ld_data,
      output inst, inst_valid, inst_err, fetch_cnt
   );

endinterface

// File: rtl/imem_ram_1r1w.sv
// DEPTH x 32 single-read single-write RAM with a registered read port, written to infer block RAM.
module imem_ram_1r1w #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // NOTE: the array and read register have no reset so they map onto block RAM; a reset forces a flop array.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking writes mean a same-edge read samples the old word (read-before-write).
      if (re_i) rdata_q <= mem_q[raddr_i];
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory end of the fetch port: decode, RAM read, LATENCY-deep response pipe, fetch counter.
module imem_responder
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] NOP_INST  = NOP_INST_DEF
) (
   input logic             clk,
   input logic             rst,
   imem_responder_if.slave imem
);

   localparam int unsigned AW = $clog2(DEPTH);

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("imem_responder: LATENCY %0d is outside 1..4", LATENCY);
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW >= IMEM_IDX_W) begin : g_bad_depth
      $error("imem_responder: DEPTH %0d must be a power of two below 2**%0d", DEPTH, IMEM_IDX_W);
   end

   imem_dec_t   fetch_dec;
   imem_dec_t   ld_dec;
   imem_req_t   fetch_req;
   logic        fetch_acc;
   logic        ram_re;
   logic        ram_we;
   logic [31:0] ram_rdata;
   logic        unused_idx_hi;

   always_comb begin
      fetch_dec     = imem_decode(imem.inst_addr, BASE_ADDR, 64'(DEPTH));
      ld_dec        = imem_decode(imem.ld_addr, BASE_ADDR, 64'(DEPTH));
      fetch_req.err = fetch_dec.misaligned | fetch_dec.out_of_range;
      fetch_req.idx = fetch_dec.idx;
   end

   assign fetch_acc     = imem.inst_ena & ~rst;
   assign ram_re        = fetch_acc & ~fetch_req.err;
   assign ram_we        = imem.ld_ena & ~rst & ~ld_dec.misaligned & ~ld_dec.out_of_range;
   assign unused_idx_hi = ^{fetch_req.idx[IMEM_IDX_W-1:AW], ld_dec.idx[IMEM_IDX_W-1:AW]};

   imem_ram_1r1w #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .re_i    (ram_re),
      .raddr_i (fetch_req.idx[AW-1:0]),
      .rdata_o (ram_rdata),
      .we_i    (ram_we),
      .waddr_i (ld_dec.idx[AW-1:0]),
      .wdata_i (imem.ld_data)
   );

   // Stage 0: the RAM read register plus its valid/err flags; clr forces inst to 0 until the first fetch after reset.
   logic      s0_valid_q;
   logic      s0_err_q;
   logic      s0_clr_q;
   imem_rsp_t s0_rsp;
   imem_rsp_t rsp_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid_q <= 1'b0;
         s0_err_q   <= 1'b0;
         s0_clr_q   <= 1'b1;
      end else begin
         s0_valid_q <= fetch_acc;
         if (fetch_acc) begin
            s0_err_q <= fetch_req.err;
            s0_clr_q <= 1'b0;
         end
      end
   end

   always_comb begin
      s0_rsp.valid = s0_valid_q;
      s0_rsp.err   = s0_err_q;
      s0_rsp.inst  = s0_clr_q ? '0 : (s0_err_q ? NOP_INST : ram_rdata);
   end

   if (LATENCY == 1) begin : g_lat1
      assign rsp_out = s0_rsp;
   end else begin : g_pipe
      imem_rsp_t pipe_q   [LATENCY-1];
      imem_rsp_t stage_in [LATENCY-1];

      for (genvar g = 0; g < LATENCY - 1; g++) begin : g_stage
         if (g == 0) begin : g_first
            assign stage_in[g] = s0_rsp;
         end else begin : g_next
            assign stage_in[g] = pipe_q[g-1];
         end

         // Data only advances with a valid beat so a bubble leaves inst holding its last value.
         always_ff @(posedge clk) begin
            if (rst) begin
               pipe_q[g] <= '0;
            end else begin
               pipe_q[g].valid <= stage_in[g].valid;
               if (stage_in[g].valid) begin
                  pipe_q[g].err  <= stage_in[g].err;
                  pipe_q[g].inst <= stage_in[g].inst;
               end
            end
         end
      end

      assign rsp_out = pipe_q[LATENCY-2];
   end

   logic [31:0] fetch_cnt_q;
   logic [31:0] fetch_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (fetch_acc && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) fetch_cnt_q <= '0;
      else     fetch_cnt_q <= fetch_cnt_d;
   end

   assign imem.inst       = rsp_out.inst;
   assign imem.inst_valid = rsp_out.valid;
   assign imem.inst_err   = rsp_out.err;
   assign imem.fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboarded bench: one stimulus stream drives responders built with LATENCY 1, 3 and 4 side by side.
module tb_imem_responder;

   localparam int NDUT = 3;

   typedef struct {
      logic [31:0] inst;
      logic        err;
      int          due;
      int          id;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        rst4;
   logic        rst_l4;
   logic        inst_ena;
   logic [63:0] inst_addr;
   logic        ld_ena;
   logic [63:0] ld_addr;
   logic [31:0] ld_data;

   int          cyc;
   int          n_checks;
   int          n_fail;
   int          vec_id;
   exp_t        sb_q [NDUT][$];
   logic [31:0] cnt_m [NDUT];

   logic [31:0] o_inst  [NDUT];
   logic        o_valid [NDUT];
   logic        o_err   [NDUT];
   logic [31:0] o_cnt   [NDUT];

   imem_responder_if if_l1 ();
   imem_responder_if if_l3 ();
   imem_responder_if if_l4 ();

   assign rst_l4 = rst | rst4;

   assign if_l1.inst_ena = inst_ena;  assign if_l1.inst_addr = inst_addr;
   assign if_l1.ld_ena   = ld_ena;    assign if_l1.ld_addr   = ld_addr;   assign if_l1.ld_data = ld_data;
   assign if_l3.inst_ena = inst_ena;  assign if_l3.inst_addr = inst_addr;
   assign if_l3.ld_ena   = ld_ena;    assign if_l3.ld_addr   = ld_addr;   assign if_l3.ld_data = ld_data;
   assign if_l4.inst_ena = inst_ena;  assign if_l4.inst_addr = inst_addr;
   assign if_l4.ld_ena   = ld_ena;    assign if_l4.ld_addr   = ld_addr;   assign if_l4.ld_data = ld_data;

   assign o_inst[0] = if_l1.inst;  assign o_valid[0] = if_l1.inst_valid;  assign o_err[0] = if_l1.inst_err;  assign o_cnt[0] = if_l1.fetch_cnt;
   assign o_inst[1] = if_l3.inst;  assign o_valid[1] = if_l3.inst_valid;  assign o_err[1] = if_l3.inst_err;  assign o_cnt[1] = if_l3.fetch_cnt;
   assign o_inst[2] = if_l4.inst;  assign o_valid[2] = if_l4.inst_valid;  assign o_err[2] = if_l4.inst_err;  assign o_cnt[2] = if_l4.fetch_cnt;

   imem_responder #(.LATENCY(1)) dut_l1 (.clk(clk), .rst(rst),    .imem(if_l1.slave));
   imem_responder #(.LATENCY(3)) dut_l3 (.clk(clk), .rst(rst),    .imem(if_l3.slave));
   imem_responder #(.LATENCY(4)) dut_l4 (.clk(clk), .rst(rst_l4), .imem(if_l4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every falling edge, match each responder's output against the head of its queue.
   task automatic sb_step(input int d);
      exp_t e;
      if (o_valid[d]) begin
         if (sb_q[d].size() == 0) begin
            check($sformatf("unexpected_valid_L%0d", lat_of(d)), 64'(o_valid[d]), 64'd0);
         end else begin
            e = sb_q[d].pop_front();
            check($sformatf("inst_L%0d_v%0d", lat_of(d), e.id), 64'(o_inst[d]), 64'(e.inst));
            check($sformatf("err_L%0d_v%0d", lat_of(d), e.id), 64'(o_err[d]), 64'(e.err));
            check($sformatf("cycle_L%0d_v%0d", lat_of(d), e.id), 64'(cyc), 64'(e.due));
         end
      end else if (sb_q[d].size() != 0 && sb_q[d][0].due <= cyc) begin
         e = sb_q[d].pop_front();
         check($sformatf("missing_rsp_L%0d_v%0d", lat_of(d), e.id), 64'(o_valid[d]), 64'd1);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) sb_step(d);
   end

   task automatic fetch(input logic [63:0] addr, input logic [31:0] exp_inst, input logic exp_err);
      inst_ena  = 1'b1;
      inst_addr = addr;
      for (int d = 0; d < NDUT; d++) begin
         sb_q[d].push_back('{inst: exp_inst, err: exp_err, due: cyc + lat_of(d), id: vec_id});
         if (cnt_m[d] != 32'hFFFF_FFFF) cnt_m[d] = cnt_m[d] + 32'd1;
      end
      vec_id++;
      @(negedge clk);
   endtask

   task automatic load(input logic [63:0] addr, input logic [31:0] data);
      ld_ena  = 1'b1;
      ld_addr = addr;
      ld_data = data;
      @(negedge clk);
      ld_ena  = 1'b0;
   endtask

   task automatic idle(input int n);
      inst_ena = 1'b0;
      ld_ena   = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int budget;
      inst_ena = 1'b0;
      budget   = 30;
      while (budget > 0 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0) begin
         @(negedge clk);
         budget--;
      end
      for (int d = 0; d < NDUT; d++)
         check($sformatf("drain_L%0d", lat_of(d)), 64'(sb_q[d].size()), 64'd0);
   endtask

   task automatic check_cnt(input string tag);
      for (int d = 0; d < NDUT; d++)
         check($sformatf("%s_cnt_L%0d", tag, lat_of(d)), 64'(o_cnt[d]), 64'(cnt_m[d]));
   endtask

   task automatic check_cleared(input int d, input string tag);
      check($sformatf("%s_inst_L%0d", tag, lat_of(d)), 64'(o_inst[d]), 64'd0);
      check($sformatf("%s_valid_L%0d", tag, lat_of(d)), 64'(o_valid[d]), 64'd0);
      check($sformatf("%s_err_L%0d", tag, lat_of(d)), 64'(o_err[d]), 64'd0);
      check($sformatf("%s_cnt_L%0d", tag, lat_of(d)), 64'(o_cnt[d]), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      vec_id    = 0;
      rst       = 1'b1;
      rst4      = 1'b0;
      inst_ena  = 1'b0;
      inst_addr = '0;
      ld_ena    = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
      for (int d = 0; d < NDUT; d++) cnt_m[d] = '0;

      repeat (3) @(negedge clk);
      for (int d = 0; d < NDUT; d++) check_cleared(d, "reset");
      rst = 1'b0;
      idle(1);

      // Preload four words and stream them back-to-back.
      load(64'h8000_0000, 32'h0000_0093);
      load(64'h8000_0004, 32'h0010_0113);
      load(64'h8000_0008, 32'h0020_0193);
      load(64'h8000_000C, 32'h0030_0213);
      fetch(64'h8000_0000, 32'h0000_0093, 1'b0);
      fetch(64'h8000_0004, 32'h0010_0113, 1'b0);
      fetch(64'h8000_0008, 32'h0020_0193, 1'b0);
      fetch(64'h8000_000C, 32'h0030_0213, 1'b0);
      drain();
      check_cnt("stream");

      // Fetch, one-cycle bubble, fetch.
      fetch(64'h8000_0004, 32'h0010_0113, 1'b0);
      idle(1);
      fetch(64'h8000_0008, 32'h0020_0193, 1'b0);
      drain();

      // Error fetches each return the NOP with the error flag.
      fetch(64'h8000_0002, 32'h0000_0013, 1'b1);
      idle(1);
      fetch(64'h8000_4000, 32'h0000_0013, 1'b1);
      idle(1);
      fetch(64'h7FFF_FFFC, 32'h0000_0013, 1'b1);
      drain();
      check_cnt("errors");

      // Out-of-range and misaligned preloads must not alias into words 0 and 1.
      load(64'h8000_4000, 32'hBAD0_BAD0);
      load(64'h8000_0006, 32'hBAD1_BAD1);
      fetch(64'h8000_0000, 32'h0000_0093, 1'b0);
      fetch(64'h8000_0004, 32'h0010_0113, 1'b0);
      drain();

      // Same-cycle preload and fetch of one word: old word first, new word next.
      load(64'h8000_0010, 32'hDEAD_BEEF);
      ld_ena  = 1'b1;
      ld_addr = 64'h8000_0010;
      ld_data = 32'h0000_0013;
      fetch(64'h8000_0010, 32'hDEAD_BEEF, 1'b0);
      ld_ena  = 1'b0;
      fetch(64'h8000_0010, 32'h0000_0013, 1'b0);
      drain();

      // Reset the LATENCY=4 responder while three fetches are in flight.
      fetch(64'h8000_0000, 32'h0000_0093, 1'b0);
      fetch(64'h8000_0004, 32'h0010_0113, 1'b0);
      fetch(64'h8000_0008, 32'h0020_0193, 1'b0);
      inst_ena = 1'b0;
      rst4     = 1'b1;
      sb_q[2].delete();
      cnt_m[2] = '0;
      @(negedge clk);
      rst4 = 1'b0;
      check_cleared(2, "midflight_rst");
      idle(8);
      drain();
      check_cnt("after_rst");
      fetch(64'h8000_0008, 32'h0020_0193, 1'b0);
      drain();
      check_cnt("refetch");

      // Backdoor the counter to one below max and run it into saturation.
      force dut_l1.fetch_cnt_q = 32'hFFFF_FFFE;
      force dut_l3.fetch_cnt_q = 32'hFFFF_FFFE;
      force dut_l4.fetch_cnt_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut_l1.fetch_cnt_q;
      release dut_l3.fetch_cnt_q;
      release dut_l4.fetch_cnt_q;
      for (int d = 0; d < NDUT; d++) cnt_m[d] = 32'hFFFF_FFFE;
      check_cnt("forced");
      fetch(64'h8000_0000, 32'h0000_0093, 1'b0);
      fetch(64'h8000_0004, 32'h0010_0113, 1'b0);
      fetch(64'h8000_0008, 32'h0020_0193, 1'b0);
      drain();
      check_cnt("saturated");
      idle(2);
      check_cnt("sat_hold");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
